// File: rtl/mem_port_arbiter_if.sv
// Bus between the cores, the shared-memory arbiter and the memory array.
// The master side is cores plus memory; the slave side is the arbiter.
interface mem_port_arbiter_if #(
  parameter int NCORES = 4,
  parameter int AW     = 10,
  parameter int DW     = 16
) ();
  logic [NCORES-1:0]    req;
  logic [NCORES*AW-1:0] req_addr;
  logic [NCORES-1:0]    req_we;
  logic [NCORES*DW-1:0] req_wdata;
  logic [NCORES-1:0]    grant;
  logic [NCORES-1:0]    ack;
  logic [DW-1:0]        rdata;
  logic [AW-1:0]        mem_addr;
  logic                 mem_we;
  logic [DW-1:0]        mem_wdata;
  logic [DW-1:0]        mem_rdata;

  modport master (
    output req, req_addr, req_we, req_wdata, mem_rdata,
    input  grant, ack, rdata, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  req, req_addr, req_we, req_wdata, mem_rdata,
    output grant, ack, rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NCORES cores:
// registered grant, one-cycle memory stage, registered ack with read data.
module mem_port_arbiter #(
  parameter int NCORES = 4,
  parameter int AW     = 10,
  parameter int DW     = 16
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  localparam int            PW   = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [PW-1:0] LAST = PW'(NCORES - 1);

  logic [NCORES-1:0] grant_r;
  logic [NCORES-1:0] ack_r;
  logic [DW-1:0]     rdata_r;
  logic [AW-1:0]     mem_addr_r;
  logic              mem_we_r;
  logic [DW-1:0]     mem_wdata_r;
  logic [PW-1:0]     ptr_r;

  logic [NCORES-1:0] eff_req_s;
  logic              found_s;
  logic              hi_found_s;
  logic [PW-1:0]     lo_win_s;
  logic [PW-1:0]     hi_win_s;
  logic [PW-1:0]     win_s;
  logic [PW-1:0]     ptr_nx_s;
  logic [NCORES-1:0] grant_nx_s;
  logic [AW-1:0]     sel_addr_s;
  logic              sel_we_s;
  logic [DW-1:0]     sel_wdata_s;

  // A core being granted this cycle cannot win again until the next cycle.
  assign eff_req_s = bus.req & ~grant_r;

  // Round-robin pick: lowest requester at or above ptr, else lowest overall.
  always_comb begin
    found_s    = 1'b0;
    hi_found_s = 1'b0;
    lo_win_s   = {PW{1'b0}};
    hi_win_s   = {PW{1'b0}};
    for (int i = NCORES - 1; i >= 0; i--) begin
      found_s    = found_s | eff_req_s[i];
      lo_win_s   = eff_req_s[i] ? PW'(i) : lo_win_s;
      hi_found_s = hi_found_s | (eff_req_s[i] & (PW'(i) >= ptr_r));
      hi_win_s   = (eff_req_s[i] && (PW'(i) >= ptr_r)) ? PW'(i) : hi_win_s;
    end
    if (hi_found_s) begin
      win_s = hi_win_s;
    end else begin
      win_s = lo_win_s;
    end
    if (win_s == LAST) begin
      ptr_nx_s = {PW{1'b0}};
    end else begin
      ptr_nx_s = win_s + PW'(1);
    end
  end

  // One-hot grant and the winner's request fields.
  always_comb begin
    grant_nx_s  = {NCORES{1'b0}};
    sel_addr_s  = {AW{1'b0}};
    sel_we_s    = 1'b0;
    sel_wdata_s = {DW{1'b0}};
    for (int i = 0; i < NCORES; i++) begin
      if (found_s && (win_s == PW'(i))) begin
        grant_nx_s[i] = 1'b1;
        sel_addr_s    = bus.req_addr[i*AW +: AW];
        sel_we_s      = bus.req_we[i];
        sel_wdata_s   = bus.req_wdata[i*DW +: DW];
      end else begin
        grant_nx_s[i] = 1'b0;
      end
    end
  end

  // Arbitration stage and memory-stage completion registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_r     <= {NCORES{1'b0}};
      ack_r       <= {NCORES{1'b0}};
      rdata_r     <= {DW{1'b0}};
      mem_addr_r  <= {AW{1'b0}};
      mem_we_r    <= 1'b0;
      mem_wdata_r <= {DW{1'b0}};
      ptr_r       <= {PW{1'b0}};
    end else begin
      ack_r   <= grant_r;
      rdata_r <= bus.mem_rdata;
      grant_r <= grant_nx_s;
      if (found_s) begin
        mem_addr_r  <= sel_addr_s;
        mem_we_r    <= sel_we_s;
        mem_wdata_r <= sel_wdata_s;
        ptr_r       <= ptr_nx_s;
      end else begin
        mem_we_r    <= 1'b0;
      end
    end
  end

  assign bus.grant     = grant_r;
  assign bus.ack       = ack_r;
  assign bus.rdata     = rdata_r;
  assign bus.mem_addr  = mem_addr_r;
  // A write in its memory stage is dropped if reset arrives in that cycle.
  assign bus.mem_we    = mem_we_r & ~reset;
  assign bus.mem_wdata = mem_wdata_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a cycle-level reference model with its own shadow memory.
module tb_mem_port_arbiter;
  localparam int NC = 4;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          clr;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  logic [NC-1:0] s_req;
  logic [NC-1:0] s_we;
  logic [AW-1:0] s_addr  [NC];
  logic [DW-1:0] s_wdata [NC];
  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] shadow  [1024];

  logic [NC-1:0] m_grant;
  logic [NC-1:0] m_ack;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  int            m_ptr;

  int errors;
  int checks;

  mem_port_arbiter_if #(.NCORES(NC), .AW(AW), .DW(DW)) bus_if ();

  mem_port_arbiter #(.NCORES(NC), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  assign bus_if.req       = s_req;
  assign bus_if.req_we    = s_we;
  assign bus_if.req_addr  = {s_addr[3], s_addr[2], s_addr[1], s_addr[0]};
  assign bus_if.req_wdata = {s_wdata[3], s_wdata[2], s_wdata[1], s_wdata[0]};
  assign bus_if.mem_rdata = mem[bus_if.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory array: clear, backdoor preload, or the arbiter's write strobe.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (bus_if.mem_we) begin
      mem[bus_if.mem_addr] <= bus_if.mem_wdata;
    end
  end

  // Reference: what the upcoming clock edge does, from the current inputs.
  task automatic model_edge();
    logic [NC-1:0] eff;
    logic [1:0]    c;
    int            w;
    if (reset) begin
      m_grant = 4'h0; m_ack = 4'h0; m_rdata = 16'h0000;
      m_addr = 10'h000; m_we = 1'b0; m_wdata = 16'h0000; m_ptr = 0;
    end else begin
      m_ack   = m_grant;
      m_rdata = shadow[m_addr];
      if (m_we) shadow[m_addr] = m_wdata;
      eff = s_req & ~m_grant;
      w = -1;
      for (int k = 0; k < NC; k++) begin
        c = 2'((m_ptr + k) % NC);
        if (w < 0 && eff[c]) w = int'(c);
      end
      if (w >= 0) begin
        c       = 2'(w);
        m_grant = 4'b0001 << c;
        m_addr  = s_addr[c];
        m_we    = s_we[c];
        m_wdata = s_wdata[c];
        m_ptr   = (w + 1) % NC;
      end else begin
        m_grant = 4'h0;
        m_we    = 1'b0;
      end
    end
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clr = 1'b1; bd_we = 1'b0; s_req = 4'h0; s_we = 4'h0;
    for (int i = 0; i < 1024; i++) shadow[i] = 16'h0000;
    advance();
    advance();
    clr = 1'b0; reset = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    advance();
    shadow[a] = d;
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (bus_if.grant !== 4'h0 || bus_if.ack !== 4'h0 || bus_if.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl grant=%b ack=%b mem_we=%b want all 0", bus_if.grant, bus_if.ack, bus_if.mem_we);
    end
    checks++;
    if (bus_if.rdata !== 16'h0000 || bus_if.mem_addr !== 10'h000 || bus_if.mem_wdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data rdata=%h mem_addr=%h mem_wdata=%h want all 0", bus_if.rdata, bus_if.mem_addr, bus_if.mem_wdata);
    end
    advance();
  endtask

  task automatic test_single_read();
    do_reset();
    preload(10'd5, 16'hBEEF);
    s_addr[1] = 10'd5; s_we[1] = 1'b0; s_req = 4'b0010;
    @(negedge clk);
    checks++;
    if (bus_if.grant !== 4'h0) begin
      errors++; $display("FAIL read_req_cycle grant=%b want 0000", bus_if.grant);
    end
    advance();
    @(negedge clk);
    checks++;
    if (bus_if.grant !== 4'b0010 || bus_if.mem_addr !== 10'd5 || bus_if.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL read_grant grant=%b addr=%0d we=%b want 0010 5 0", bus_if.grant, bus_if.mem_addr, bus_if.mem_we);
    end
    s_req = 4'h0;
    advance();
    @(negedge clk);
    checks++;
    if (bus_if.ack !== 4'b0010 || bus_if.rdata !== 16'hBEEF || bus_if.grant !== 4'h0) begin
      errors++;
      $display("FAIL read_ack ack=%b rdata=%h grant=%b want 0010 beef 0000", bus_if.ack, bus_if.rdata, bus_if.grant);
    end
    advance();
  endtask

  task automatic test_full_contention();
    logic [NC-1:0] eg [7];
    logic [NC-1:0] ea [7];
    int            cnt [NC];
    eg = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
    ea = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    do_reset();
    for (int i = 0; i < NC; i++) begin
      s_addr[i] = AW'(100 + i); s_we[i] = 1'b0; cnt[i] = 0;
    end
    s_req = 4'hF;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (bus_if.grant !== eg[c] || bus_if.ack !== ea[c]) begin
        errors++;
        $display("FAIL contention cyc=%0d grant=%b ack=%b want %b %b", c, bus_if.grant, bus_if.ack, eg[c], ea[c]);
      end
      for (int i = 0; i < NC; i++) begin
        if (bus_if.grant[i]) begin cnt[i]++; s_req[i] = 1'b0; end
      end
      advance();
    end
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (cnt[i] != 1) begin
        errors++; $display("FAIL contention_count core=%0d grants=%0d want 1", i, cnt[i]);
      end
    end
  endtask

  task automatic test_rotation_wrap();
    logic [NC-1:0] eg [5];
    eg = '{4'h0, 4'h8, 4'h1, 4'h8, 4'h0};
    do_reset();
    s_addr[0] = 10'd30; s_addr[3] = 10'd33; s_we = 4'h0;
    s_req = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus_if.grant !== eg[c]) begin
        errors++; $display("FAIL rotation cyc=%0d grant=%b want %b", c, bus_if.grant, eg[c]);
      end
      case (c)
        1:       s_req = 4'b1001;
        2:       s_req[0] = 1'b0;
        3:       s_req[3] = 1'b0;
        default: s_req = s_req;
      endcase
      advance();
    end
  endtask

  task automatic test_write_then_read();
    int wes;
    wes = 0;
    do_reset();
    s_addr[2] = 10'd9; s_we[2] = 1'b1; s_wdata[2] = 16'h1234;
    s_req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus_if.mem_we === 1'b1) wes++;
      if (c == 1) begin
        checks++;
        if (bus_if.grant !== 4'b0100 || bus_if.mem_we !== 1'b1 || bus_if.mem_wdata !== 16'h1234) begin
          errors++;
          $display("FAIL wr_grant grant=%b we=%b wdata=%h want 0100 1 1234", bus_if.grant, bus_if.mem_we, bus_if.mem_wdata);
        end
        s_req = 4'b0001; s_addr[0] = 10'd9; s_we[0] = 1'b0;
      end else if (c == 2) begin
        checks++;
        if (bus_if.grant !== 4'b0001 || bus_if.ack !== 4'b0100) begin
          errors++; $display("FAIL rd_grant grant=%b ack=%b want 0001 0100", bus_if.grant, bus_if.ack);
        end
        s_req = 4'h0;
      end else if (c == 3) begin
        checks++;
        if (bus_if.ack !== 4'b0001 || bus_if.rdata !== 16'h1234) begin
          errors++; $display("FAIL rd_after_wr ack=%b rdata=%h want 0001 1234", bus_if.ack, bus_if.rdata);
        end
      end
      advance();
    end
    checks++;
    if (wes != 1) begin
      errors++; $display("FAIL wr_strobe_cycles got=%0d want 1", wes);
    end
  endtask

  task automatic test_held_request();
    logic [NC-1:0] eg [8];
    logic [NC-1:0] prev;
    eg = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0};
    prev = 4'h0;
    do_reset();
    s_addr[0] = 10'd3; s_we[0] = 1'b0;
    s_req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (bus_if.grant !== eg[c] || (prev != 4'h0 && bus_if.grant != 4'h0)) begin
        errors++; $display("FAIL held cyc=%0d grant=%b prev=%b want %b", c, bus_if.grant, prev, eg[c]);
      end
      prev = bus_if.grant;
      if (c == 5) s_req = 4'h0;
      advance();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    preload(10'd20, 16'hAAAA);
    s_addr[2] = 10'd20; s_we[2] = 1'b1; s_wdata[2] = 16'h5555;
    s_req = 4'b0100;
    @(negedge clk);
    advance();
    @(negedge clk);
    checks++;
    if (bus_if.grant !== 4'b0100 || bus_if.mem_we !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre grant=%b we=%b want 0100 1", bus_if.grant, bus_if.mem_we);
    end
    s_req = 4'h0; s_we = 4'h0;
    reset = 1'b1;
    #1;
    checks++;
    if (bus_if.mem_we !== 1'b0) begin
      errors++; $display("FAIL rstmid_we_gate mem_we=%b want 0", bus_if.mem_we);
    end
    advance();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.grant !== 4'h0 || bus_if.ack !== 4'h0 || bus_if.mem_we !== 1'b0 ||
        bus_if.mem_addr !== 10'h000 || bus_if.mem_wdata !== 16'h0000 || bus_if.rdata !== 16'h0000) begin
      errors++;
      $display("FAIL rstmid_outputs grant=%b ack=%b we=%b addr=%h wdata=%h rdata=%h want all 0",
               bus_if.grant, bus_if.ack, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, bus_if.rdata);
    end
    checks++;
    if (mem[20] !== 16'hAAAA) begin
      errors++; $display("FAIL rstmid_mem mem[20]=%h want aaaa", mem[20]);
    end
    s_addr[0] = 10'd1; s_addr[3] = 10'd2; s_req = 4'b1001;
    advance();
    @(negedge clk);
    checks++;
    if (bus_if.grant !== 4'b0001) begin
      errors++; $display("FAIL rstmid_ptr grant=%b want 0001", bus_if.grant);
    end
    s_req[0] = 1'b0;
    advance();
    @(negedge clk);
    checks++;
    if (bus_if.grant !== 4'b1000 || bus_if.ack !== 4'b0001) begin
      errors++; $display("FAIL rstmid_resume grant=%b ack=%b want 1000 0001", bus_if.grant, bus_if.ack);
    end
    s_req = 4'h0;
    advance();
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if (bus_if.grant !== m_grant || bus_if.ack !== m_ack || bus_if.rdata !== m_rdata) begin
        errors++;
        $display("FAIL rand_resp cyc=%0d grant=%b ack=%b rdata=%h want %b %b %h",
                 c, bus_if.grant, bus_if.ack, bus_if.rdata, m_grant, m_ack, m_rdata);
      end
      checks++;
      if (bus_if.mem_addr !== m_addr || bus_if.mem_we !== m_we || bus_if.mem_wdata !== m_wdata) begin
        errors++;
        $display("FAIL rand_mem cyc=%0d addr=%h we=%b wdata=%h want %h %b %h",
                 c, bus_if.mem_addr, bus_if.mem_we, bus_if.mem_wdata, m_addr, m_we, m_wdata);
      end
      for (int i = 0; i < NC; i++) begin
        if (!s_req[i] || bus_if.grant[i]) begin
          if ($urandom_range(0, 99) < 45) begin
            s_req[i]   = 1'b1;
            s_addr[i]  = AW'($urandom_range(0, 7));
            s_we[i]    = 1'($urandom_range(0, 1));
            s_wdata[i] = DW'($urandom);
          end else begin
            s_req[i] = 1'b0;
          end
        end
      end
      advance();
    end
    s_req = 4'h0;
    advance();
    advance();
    advance();
    for (int a = 0; a < 8; a++) begin
      checks++;
      if (mem[a] !== shadow[a]) begin
        errors++; $display("FAIL rand_final_mem addr=%0d got=%h want %h", a, mem[a], shadow[a]);
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; clr = 1'b0; bd_we = 1'b0; bd_addr = 10'h000; bd_data = 16'h0000;
    s_req = 4'h0; s_we = 4'h0;
    for (int i = 0; i < NC; i++) begin s_addr[i] = 10'h000; s_wdata[i] = 16'h0000; end
    m_grant = 4'h0; m_ack = 4'h0; m_rdata = 16'h0000;
    m_addr = 10'h000; m_we = 1'b0; m_wdata = 16'h0000; m_ptr = 0;
    test_reset();
    test_single_read();
    test_full_contention();
    test_rotation_wrap();
    test_write_then_read();
    test_held_request();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog run did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
